// File: rtl/keycode_event_scheduler.sv
// Keycode event scheduler: turns the two-key snapshot from a keycode PIO into
// a queue of press / release / auto-repeat events for a consumer.
module keycode_event_scheduler #(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 50000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [15:0]                   keycode_in,
  input  logic                          flush,
  input  logic                          ovf_clr,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic [1:0]                    evt_type,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [1:0] T_PRESS = 2'b01;
  localparam logic [1:0] T_REL   = 2'b10;
  localparam logic [1:0] T_REP   = 2'b11;

  typedef enum logic [2:0] {IDLE, REL0, REL1, PRS0, PRS1} state_t;

  state_t          state, state_nx;
  logic [15:0]     prev, cur;
  logic [7:0]      rkey;
  logic [RW-1:0]   rcnt;
  logic            rphase;            // 0: initial delay, 1: periodic
  logic [9:0]      mem [FIFO_DEPTH];  // {type, code}
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count, count_nx;

  logic       change, rep_tick, rep_hit;
  logic       rel0_ok, rel1_ok, prs0_ok, prs1_ok;
  logic       push, pop, full, do_push, drop;
  logic [7:0] push_code;
  logic [1:0] push_type;
  logic [7:0] p0, p1, c0, c1;

  assign p0 = prev[7:0];
  assign p1 = prev[15:8];
  assign c0 = cur[7:0];
  assign c1 = cur[15:8];

  // A key is released if it vanished from the snapshot, pressed if it is new;
  // duplicate slots only generate one event.
  assign rel0_ok = (p0 != 8'h00) && (p0 != c0) && (p0 != c1);
  assign rel1_ok = (p1 != 8'h00) && (p1 != c0) && (p1 != c1) && (p1 != p0);
  assign prs0_ok = (c0 != 8'h00) && (c0 != p0) && (c0 != p1);
  assign prs1_ok = (c1 != 8'h00) && (c1 != p0) && (c1 != p1) && (c1 != c0);

  assign change   = (state == IDLE) && (keycode_in != prev);
  assign rep_tick = (state == IDLE) && !change && (rkey != 8'h00);
  assign rep_hit  = rep_tick &&
                    (rcnt == (rphase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1)));

  assign evt_valid  = (count != '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign pop        = evt_valid && evt_ready;
  assign do_push    = push && (!full || pop);
  assign drop       = push && full && !pop;
  assign evt_code   = evt_valid ? mem[rptr][7:0] : 8'h00;
  assign evt_type   = evt_valid ? mem[rptr][9:8] : 2'b00;
  assign fifo_count = count;
  assign busy       = (state != IDLE);

  // Next-state and single event source per cycle (FSM slot or repeat tick)
  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    push_code = 8'h00;
    push_type = 2'b00;
    case (state)
      IDLE: begin
        if (change) state_nx = REL0;
        else if (rep_hit) begin
          push = 1'b1; push_code = rkey; push_type = T_REP;
        end
      end
      REL0: begin
        state_nx = REL1;
        if (rel0_ok) begin push = 1'b1; push_code = p0; push_type = T_REL; end
      end
      REL1: begin
        state_nx = PRS0;
        if (rel1_ok) begin push = 1'b1; push_code = p1; push_type = T_REL; end
      end
      PRS0: begin
        state_nx = PRS1;
        if (prs0_ok) begin push = 1'b1; push_code = c0; push_type = T_PRESS; end
      end
      PRS1: begin
        state_nx = IDLE;
        if (prs1_ok) begin push = 1'b1; push_code = c1; push_type = T_PRESS; end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Occupancy update; full+push+pop keeps the count steady
  always_comb begin
    count_nx = count;
    case ({do_push, pop})
      2'b10:   count_nx = count + CW'(1);
      2'b01:   count_nx = count - CW'(1);
      default: count_nx = count;
    endcase
  end

  // FSM, snapshots and auto-repeat tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE; prev <= '0; cur <= '0;
      rkey <= '0; rcnt <= '0; rphase <= 1'b0;
    end else if (flush) begin
      state <= IDLE; prev <= '0; cur <= '0;
      rkey <= '0; rcnt <= '0; rphase <= 1'b0;
    end else begin
      state <= state_nx;
      if (change) cur <= keycode_in;
      if (state == PRS1) prev <= cur;
      if (push && push_type == T_PRESS) begin
        rkey <= push_code; rcnt <= '0; rphase <= 1'b0;
      end else if (push && push_type == T_REL && push_code == rkey) begin
        rkey <= '0; rcnt <= '0;
      end else if (rep_hit) begin
        rcnt <= '0; rphase <= 1'b1;
      end else if (rep_tick) begin
        rcnt <= rcnt + RW'(1);
      end
    end
  end

  // Queue pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0; rptr <= '0; count <= '0; overflow <= 1'b0;
    end else if (flush) begin
      wptr <= '0; rptr <= '0; count <= '0; overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      count <= count_nx;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Queue storage; contents are masked by evt_valid so no reset needed
  always_ff @(posedge clk) begin
    if (!flush && do_push) mem[wptr] <= {push_type, push_code};
  end
endmodule

// File: tb/tb_keycode_event_scheduler.sv
// Directed bench for keycode_event_scheduler (depth 2, short repeat timing).
module tb_keycode_event_scheduler;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] keycode_in;
  logic        flush, ovf_clr, evt_ready;
  logic        evt_valid, overflow, busy;
  logic [7:0]  evt_code;
  logic [1:0]  evt_type;
  logic [1:0]  fifo_count;

  int tests = 0;
  int failed = 0;

  keycode_event_scheduler #(.FIFO_DEPTH(2), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut (
    .clk(clk), .reset_n(reset_n), .keycode_in(keycode_in), .flush(flush),
    .ovf_clr(ovf_clr), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_type(evt_type), .fifo_count(fifo_count),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] kc;
    logic        rdy;
    logic        fl;
    logic        v;
    logic [7:0]  code;
    logic [1:0]  typ;
    logic [1:0]  cnt;
    logic        bsy;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_evt(input string nm, input logic v, input logic [7:0] c, input logic [1:0] t);
    chk({nm, ".valid"}, {31'd0, evt_valid}, {31'd0, v});
    chk({nm, ".code"},  {24'd0, evt_code},  {24'd0, c});
    chk({nm, ".type"},  {30'd0, evt_type},  {30'd0, t});
  endtask

  initial begin
    // press 0x04, then 0x0004->0x1605, then 0x1605->0x0516 (no events), then flush
    vt[0]  = '{16'h0004, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b1};
    vt[1]  = '{16'h0004, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b1};
    vt[2]  = '{16'h0004, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b1};
    vt[3]  = '{16'h0004, 1'b1, 1'b0, 1'b1, 8'h04, 2'd1, 2'd1, 1'b1};
    vt[4]  = '{16'h0004, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b0};
    vt[5]  = '{16'h1605, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b1};
    vt[6]  = '{16'h1605, 1'b1, 1'b0, 1'b1, 8'h04, 2'd2, 2'd1, 1'b1};
    vt[7]  = '{16'h1605, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b1};
    vt[8]  = '{16'h1605, 1'b1, 1'b0, 1'b1, 8'h05, 2'd1, 2'd1, 1'b1};
    vt[9]  = '{16'h1605, 1'b1, 1'b0, 1'b1, 8'h16, 2'd1, 2'd1, 1'b0};
    vt[10] = '{16'h0516, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b1};
    vt[11] = '{16'h0516, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b1};
    vt[12] = '{16'h0516, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b1};
    vt[13] = '{16'h0516, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b1};
    vt[14] = '{16'h0516, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b0};
    vt[15] = '{16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 2'd0, 1'b0};
    vt[16] = '{16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b0};

    reset_n = 1'b0; keycode_in = 16'h0000; flush = 1'b0; ovf_clr = 1'b0; evt_ready = 1'b1;
    #3;
    chk_evt("reset", 1'b0, 8'h00, 2'd0);
    chk("reset.count", {30'd0, fifo_count}, 32'd0);
    chk("reset.ovf",   {31'd0, overflow},   32'd0);
    chk("reset.busy",  {31'd0, busy},       32'd0);
    step(); step();
    reset_n = 1'b1;

    // table-driven: press / release / simultaneous-swap / flush
    for (int i = 0; i < 17; i++) begin
      keycode_in = vt[i].kc; evt_ready = vt[i].rdy; flush = vt[i].fl;
      step();
      chk_evt($sformatf("vec%0d", i), vt[i].v, vt[i].code, vt[i].typ);
      chk($sformatf("vec%0d.count", i), {30'd0, fifo_count}, {30'd0, vt[i].cnt});
      chk($sformatf("vec%0d.busy", i),  {31'd0, busy},       {31'd0, vt[i].bsy});
    end
    flush = 1'b0;

    // auto-repeat: hold 0x07, repeat after 10 idle cycles then every 4, stop on release
    keycode_in = 16'h0007;
    for (int i = 0; i < 46; i++) begin
      logic       ev;
      logic [1:0] et;
      if (i == 23) keycode_in = 16'h0000;
      step();
      ev = 1'b1;
      if (i == 3)                            et = 2'd1;
      else if (i == 14 || i == 18 || i == 22) et = 2'd3;
      else if (i == 24)                      et = 2'd2;
      else begin ev = 1'b0; et = 2'd0; end
      chk_evt($sformatf("rep%0d", i), ev, ev ? 8'h07 : 8'h00, et);
    end

    // overflow with depth 2, consumer stalled
    evt_ready = 1'b0; keycode_in = 16'h0201;
    repeat (5) step();
    chk("ovf.count_full", {30'd0, fifo_count}, 32'd2);
    chk("ovf.pre",        {31'd0, overflow},   32'd0);
    chk_evt("ovf.head", 1'b1, 8'h01, 2'd1);
    keycode_in = 16'h0000;
    step(); step();
    chk("ovf.set",   {31'd0, overflow},   32'd1);
    chk("ovf.count", {30'd0, fifo_count}, 32'd2);
    ovf_clr = 1'b1;
    step();
    chk("ovf.drop_vs_clr", {31'd0, overflow}, 32'd1);
    step();
    chk("ovf.cleared", {31'd0, overflow}, 32'd0);
    ovf_clr = 1'b0;
    step();
    chk_evt("ovf.head2", 1'b1, 8'h01, 2'd1);

    // push and pop on a full queue in the same cycle
    keycode_in = 16'h0003;
    repeat (3) step();
    evt_ready = 1'b1;
    step();
    chk("fullpp.count", {30'd0, fifo_count}, 32'd2);
    chk("fullpp.ovf",   {31'd0, overflow},   32'd0);
    chk_evt("fullpp.head", 1'b1, 8'h02, 2'd1);
    step();
    chk("fullpp.count2", {30'd0, fifo_count}, 32'd1);
    chk_evt("fullpp.head2", 1'b1, 8'h03, 2'd1);
    keycode_in = 16'h0000; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush.count", {30'd0, fifo_count}, 32'd0);

    // asynchronous reset while in REL1 with events queued
    evt_ready = 1'b0; keycode_in = 16'h0009;
    repeat (5) step();
    keycode_in = 16'h0000;
    step(); step();
    chk("rst.pre_count", {30'd0, fifo_count}, 32'd2);
    chk("rst.pre_busy",  {31'd0, busy},       32'd1);
    reset_n = 1'b0;
    #1;
    chk_evt("rst.async", 1'b0, 8'h00, 2'd0);
    chk("rst.count", {30'd0, fifo_count}, 32'd0);
    chk("rst.ovf",   {31'd0, overflow},   32'd0);
    chk("rst.busy",  {31'd0, busy},       32'd0);
    step();
    reset_n = 1'b1; evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("rst.quiet%0d.valid", i), {31'd0, evt_valid}, 32'd0);
      chk($sformatf("rst.quiet%0d.busy", i),  {31'd0, busy},      32'd0);
    end
    keycode_in = 16'h0011;
    repeat (4) step();
    chk_evt("rst.after", 1'b1, 8'h11, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
